// File: rtl/sccb_target.sv
// sccb_target: SCCB responder (camera-side target) with a 256x8 register file.
// Handles the 3-phase write, the 2-phase write that sets the read pointer, and the
// 2-phase read. There is no sub-address auto-increment.
//
// Ports:
//   clk       system clock, at least 8x the SIOC rate
//   rst       synchronous active-high reset
//   sioc_in   resolved SIOC bus level
//   siod_in   resolved SIOD bus level
//   siod_oe   1 = pull SIOD low
//   wr_en     one-clk strobe per completed register write
//   wr_addr   address of the write, valid with wr_en
//   wr_data   data of the write, valid with wr_en
//   busy      high from START until STOP or abort
//   dbg_addr  debug read address into the register file
//   dbg_data  reg_file[dbg_addr], combinational
//
// Build option: define SCCB_TARGET_ACK_EN to pull SIOD low during the X bit of each
// accepted ID/ADDR/DATA byte (I2C-style ACK). By default the X bit is never driven.
module sccb_target #(
  parameter logic [7:0]  DEVICE_ID = 8'h42,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_ADDR,
    S_DATA,
    S_RDATA,
    S_WAIT_STOP
  } state_t;

  logic [SYNC_STG-1:0] sioc_sync;
  logic [SYNC_STG-1:0] siod_sync;
  logic                sioc_s, siod_s;
  logic                sioc_q, siod_q;
  logic                sioc_rise, sioc_fall;
  logic                start_det, stop_det;
  logic                ack_now;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rd_byte;
  logic [7:0] sub_addr;
  logic [7:0] reg_file [256];

  // Synchronizers and previous-sample flops; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      sioc_q    <= 1'b1;
      siod_q    <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_STG-2:0], sioc_in};
      siod_sync <= {siod_sync[SYNC_STG-2:0], siod_in};
      sioc_q    <= sioc_s;
      siod_q    <= siod_s;
    end
  end

  assign sioc_s = sioc_sync[SYNC_STG-1];
  assign siod_s = siod_sync[SYNC_STG-1];

  // START/STOP require SIOC high in both samples, so a simultaneous SIOC+SIOD change
  // is seen only as a clock edge.
  always_comb begin
    sioc_rise = sioc_s & ~sioc_q;
    sioc_fall = ~sioc_s & sioc_q;
    start_det = sioc_s & sioc_q & siod_q & ~siod_s;
    stop_det  = sioc_s & sioc_q & ~siod_q & siod_s;
  end

`ifdef SCCB_TARGET_ACK_EN
  always_comb begin
    ack_now = 1'b0;
    case (state)
      S_ID:           ack_now = (shreg == DEVICE_ID) || (shreg == READ_ID);
      S_ADDR, S_DATA: ack_now = 1'b1;
      default:        ack_now = 1'b0;
    endcase
  end
`else
  assign ack_now = 1'b0;
`endif

  assign dbg_data = reg_file[dbg_addr];

  // bit_cnt counts SIOC rising edges within a byte: 1..8 data bits, 9 = X bit.
  // The byte is acted on at the falling edge that ends the X bit (bit_cnt == 9).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rd_byte  <= '0;
      sub_addr <= '0;
      siod_oe  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      for (int unsigned i = 0; i < 256; i++) begin
        reg_file[8'(i)] <= '0;
      end
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        state   <= S_ID;
        bit_cnt <= '0;
        siod_oe <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        siod_oe <= 1'b0;
        busy    <= 1'b0;
      end else if (state != S_IDLE && state != S_WAIT_STOP) begin
        if (sioc_rise && bit_cnt != 4'd9) begin
          if (bit_cnt < 4'd8) begin
            shreg <= {shreg[6:0], siod_s};
          end
          bit_cnt <= bit_cnt + 4'd1;
        end else if (sioc_fall) begin
          if (bit_cnt == 4'd9) begin
            bit_cnt <= '0;
            siod_oe <= 1'b0;
            case (state)
              S_ID: begin
                if (shreg == DEVICE_ID) begin
                  state <= S_ADDR;
                end else if (shreg == READ_ID) begin
                  // First read bit goes out on this same falling edge.
                  state   <= S_RDATA;
                  rd_byte <= reg_file[sub_addr];
                  siod_oe <= ~reg_file[sub_addr][7];
                end else begin
                  state <= S_WAIT_STOP;
                end
              end
              S_ADDR: begin
                sub_addr <= shreg;
                state    <= S_DATA;
              end
              S_DATA: begin
                reg_file[sub_addr] <= shreg;
                wr_en   <= 1'b1;
                wr_addr <= sub_addr;
                wr_data <= shreg;
                state   <= S_WAIT_STOP;
              end
              default: state <= S_WAIT_STOP;
            endcase
          end else if (bit_cnt == 4'd8) begin
            siod_oe <= ack_now;
          end else if (state == S_RDATA && bit_cnt != 4'd0) begin
            // After k sampled bits, bit 7-k is presented; ~k in 3 bits equals 7-k.
            siod_oe <= ~rd_byte[~bit_cnt[2:0]];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: drives an SCCB master onto an open-drain bus model opposite
// sccb_target and compares against a transaction-level model of the register file,
// the read pointer and the expected write strobes.
module tb_sccb_target;

  localparam int         Q   = 4;        // clk cycles per SIOC quarter period
  localparam logic [7:0] DEV = 8'h42;
`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sioc_m = 1'b1;
  logic       siod_m = 1'b1;
  logic       sioc_in, siod_in;
  logic       siod_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, dbg_data;
  logic [7:0] dbg_addr = '0;

  int passed = 0;
  int total  = 0;

  logic [7:0]  model_reg [256];
  logic [7:0]  model_sub;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  assign sioc_in = sioc_m;
  assign siod_in = siod_m & ~siod_oe;

  sccb_target #(.DEVICE_ID(8'h42), .SYNC_STG(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sioc_in  (sioc_in),
    .siod_in  (siod_in),
    .siod_oe  (siod_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_en_unexpected", {31'd0, wr_en}, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
        check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_reg[i] = 8'h00;
    model_sub = 8'h00;
  endtask

  task automatic bus_start();
    if (sioc_m == 1'b0) begin
      siod_m = 1'b1; wclk(Q);
      sioc_m = 1'b1; wclk(Q);
    end
    siod_m = 1'b0; wclk(2 * Q);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    sioc_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop();
    siod_m = 1'b0; wclk(Q);
    sioc_m = 1'b1; wclk(Q);
    siod_m = 1'b1; wclk(2 * Q);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    check("oe_after_stop", {31'd0, siod_oe}, 32'd0);
  endtask

  // One SIOC pulse; target's siod_oe checked mid-high.
  task automatic send_bit(input logic b, input logic exp_oe, input string nm);
    siod_m = b;   wclk(Q);
    sioc_m = 1'b1; wclk(Q);
    check(nm, {31'd0, siod_oe}, {31'd0, exp_oe});
    wclk(Q);
    sioc_m = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, {nm, "_bit_oe"});
    send_bit(1'b1, exp_ack, {nm, "_x_oe"});
  endtask

  task automatic read_byte(input logic [7:0] exp, output logic [7:0] got);
    logic drive;
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      drive = ~exp[i];
      siod_m = 1'b1; wclk(Q);
      sioc_m = 1'b1; wclk(Q);
      got[i] = siod_in;
      check("rd_bit_oe", {31'd0, siod_oe}, {31'd0, drive});
      wclk(Q);
      sioc_m = 1'b0; wclk(Q);
    end
    send_bit(1'b1, 1'b0, "rd_x_oe");
  endtask

  task automatic tr_write(input logic [7:0] a, input logic [7:0] d);
    model_sub    = a;
    model_reg[a] = d;
    exp_q.push_back({a, d});
    bus_start();
    send_byte(DEV, ACK, "wid");
    send_byte(a, ACK, "waddr");
    send_byte(d, ACK, "wdata");
    bus_stop();
  endtask

  task automatic tr_setaddr(input logic [7:0] a);
    model_sub = a;
    bus_start();
    send_byte(DEV, ACK, "sid");
    send_byte(a, ACK, "saddr");
    bus_stop();
  endtask

  task automatic tr_read(output logic [7:0] got);
    logic [7:0] exp;
    exp = model_reg[model_sub];
    bus_start();
    send_byte(DEV | 8'h01, ACK, "rid");
    read_byte(exp, got);
    bus_stop();
    check("rd_byte", {24'd0, got}, {24'd0, exp});
  endtask

  task automatic tr_wrong(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d);
    bus_start();
    send_byte(id, 1'b0, "xid");
    send_byte(a, 1'b0, "xaddr");
    send_byte(d, 1'b0, "xdata");
    bus_stop();
  endtask

  task automatic tr_partial(input logic [7:0] a, input logic [7:0] d, input int n);
    model_sub = a;
    bus_start();
    send_byte(DEV, ACK, "pid");
    send_byte(a, ACK, "paddr");
    for (int i = 7; i > 7 - n; i--) send_bit(d[i], 1'b0, "pdata_oe");
    bus_stop();
  endtask

  task automatic check_dbg(input string nm, input logic [7:0] a);
    dbg_addr = a;
    #1;
    check(nm, {24'd0, dbg_data}, {24'd0, model_reg[a]});
  endtask

  task automatic check_dbg_lit(input string nm, input logic [7:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1;
    check(nm, {24'd0, dbg_data}, {24'd0, v});
  endtask

  task automatic check_reset_outputs();
    check("rst_siod_oe", {31'd0, siod_oe}, 32'd0);
    check("rst_wr_en",   {31'd0, wr_en},   32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
  endtask

  initial begin
    logic [7:0] got, id, a, d;
    int         op;

    model_reset();
    rst = 1'b1;
    wclk(3);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    wclk(4);
    check_dbg_lit("rst_reg_00", 8'h00, 8'h00);
    check_dbg_lit("rst_reg_ff", 8'hFF, 8'h00);

    // Basic 3-phase write.
    tr_write(8'hAA, 8'h77);
    check_dbg_lit("wr_aa", 8'hAA, 8'h77);

    // Foreign device ID is ignored.
    tr_wrong(8'h60, 8'h10, 8'h55);
    check_dbg_lit("wrong_id_10", 8'h10, 8'h00);

    // Write, set pointer with a 2-phase write, then read back.
    tr_write(8'h0A, 8'h3C);
    tr_setaddr(8'h0A);
    tr_read(got);
    check("rd_lit_3c", {24'd0, got}, 32'h3C);

    // STOP inside the DATA byte discards it; the next full write lands.
    tr_partial(8'h01, 8'h5A, 4);
    check_dbg_lit("partial_01", 8'h01, 8'h00);
    tr_write(8'h01, 8'h99);
    check_dbg_lit("wr_01", 8'h01, 8'h99);

    // Reset in the middle of the ADDR byte.
    bus_start();
    send_byte(DEV, ACK, "mid_id");
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, "mid_addr_oe");
    check("busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    model_reset();
    siod_m = 1'b1; wclk(Q);
    sioc_m = 1'b1; wclk(2 * Q);
    check_dbg_lit("rst_clr_aa", 8'hAA, 8'h00);
    tr_write(8'h33, 8'hC5);
    tr_read(got);
    check("rd_lit_c5", {24'd0, got}, 32'hC5);

    // Randomized traffic against the model.
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 4);
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      case (op)
        0: tr_write(a, d);
        1: tr_setaddr(a);
        2: tr_read(got);
        3: begin
          id = 8'($urandom_range(0, 255));
          if (id[7:1] == DEV[7:1]) id = id ^ 8'h80;
          tr_wrong(id, a, d);
        end
        default: tr_partial(a, d, $urandom_range(1, 7));
      endcase
      check_dbg("dbg_sub", model_sub);
      check_dbg("dbg_rand", 8'($urandom_range(0, 255)));
    end

    wclk(4);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
